// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one stb/ack floating-point multiplier among N_REQ requesters.
// Define FPU_MUL_ARB_PERF_EN to add the ops_done / busy_cycles performance counters.
module fpu_mul_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [N_REQ-1:0]     req_stb,
  output logic [N_REQ-1:0]     req_ack,
  output logic [31:0]          res_z,
  output logic [N_REQ-1:0]     res_stb,
  input  logic [N_REQ-1:0]     res_ack,
  output logic [31:0]          mul_a,
  output logic                 mul_a_stb,
  input  logic                 mul_a_ack,
  output logic [31:0]          mul_b,
  output logic                 mul_b_stb,
  input  logic                 mul_b_ack,
  input  logic [31:0]          mul_z,
  input  logic                 mul_z_stb,
  output logic                 mul_z_ack,
`ifdef FPU_MUL_ARB_PERF_EN
  output logic [31:0]          ops_done,
  output logic [31:0]          busy_cycles,
`endif
  output logic                 busy
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [GW-1:0] LAST = GW'(N_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_Z,
    DELIVER
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       z_q, z_d;
  logic [N_REQ-1:0]  req_ack_q, req_ack_d;

  logic [31:0]       a_arr [N_REQ];
  logic [31:0]       b_arr [N_REQ];
  logic              pick_vld;
  logic [GW-1:0]     pick_idx;
  logic [GW-1:0]     sel_idx;
  logic              deliver_done;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[32*i +: 32];
    assign b_arr[i] = req_b[32*i +: 32];
  end

  // Scan starting at rr_ptr and wrapping; the first pending requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    sel_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sel_idx = GW'((32'(rr_ptr_q) + k) % N_REQ);
      if (!pick_vld && req_stb[sel_idx]) begin
        pick_vld = 1'b1;
        pick_idx = sel_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    a_d          = a_q;
    b_d          = b_q;
    z_d          = z_q;
    req_ack_d    = '0;
    mul_a_stb    = 1'b0;
    mul_b_stb    = 1'b0;
    mul_z_ack    = 1'b0;
    deliver_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d               = pick_idx;
          a_d                 = a_arr[pick_idx];
          b_d                 = b_arr[pick_idx];
          req_ack_d[pick_idx] = 1'b1;
          state_d             = SEND_A;
        end
      end
      SEND_A: begin
        mul_a_stb = 1'b1;
        if (mul_a_ack) state_d = SEND_B;
      end
      SEND_B: begin
        mul_b_stb = 1'b1;
        if (mul_b_ack) state_d = WAIT_Z;
      end
      WAIT_Z: begin
        if (mul_z_stb) begin
          mul_z_ack = 1'b1;
          z_d       = mul_z;
          state_d   = DELIVER;
        end
      end
      DELIVER: begin
        // Only the winner's res_ack can retire the result.
        if (res_ack[gnt_q]) begin
          deliver_done = 1'b1;
          rr_ptr_d     = (gnt_q == LAST) ? '0 : gnt_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      z_q       <= '0;
      req_ack_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      z_q       <= z_d;
      req_ack_q <= req_ack_d;
    end
  end

  always_comb begin
    res_stb = '0;
    if (state_q == DELIVER) res_stb[gnt_q] = 1'b1;
  end

  assign req_ack = req_ack_q;
  assign res_z   = z_q;
  assign mul_a   = a_q;
  assign mul_b   = b_q;
  assign busy    = (state_q != IDLE);

`ifdef FPU_MUL_ARB_PERF_EN
  logic [31:0] ops_done_q, ops_done_d;
  logic [31:0] busy_cycles_q, busy_cycles_d;

  always_comb begin
    ops_done_d    = ops_done_q;
    busy_cycles_d = busy_cycles_q;
    if (deliver_done) ops_done_d = ops_done_q + 32'd1;
    if (busy && (busy_cycles_q != '1)) busy_cycles_d = busy_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done_q    <= '0;
      busy_cycles_q <= '0;
    end else begin
      ops_done_q    <= ops_done_d;
      busy_cycles_q <= busy_cycles_d;
    end
  end

  assign ops_done    = ops_done_q;
  assign busy_cycles = busy_cycles_q;
`endif

endmodule
